// File: rtl/ft245_pkg.sv
// Shared types for the FT245 bridge: FSM states, arbitration direction, level width helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ft245_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_GAP
    } state_e;

    typedef enum logic {
        DIR_RX = 1'b0,
        DIR_TX = 1'b1
    } dir_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ft245_bridge_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Latency: a push is visible at pop_dat/level one clock later; pop_dat is the live head.
// Backpressure: pushes while full and pops while empty are ignored; caller watches full/empty.
module sync_fifo
    import ft245_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_dat,
    input  logic                      pop,
    output logic [DATA_W-1:0]         pop_dat,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/ft245_bridge.sv
// FT245-style parallel FIFO bridge: synchronised txe/rxf flags, timed rd/wr strobes, buffered streams.
// Latency: read = 1 + STROBE + GAP clocks; write = SETUP + STROBE + 1 + GAP + 1 clocks per byte.
// Backpressure: tx_ready drops when the TX FIFO is full; pad reads stall while the RX FIFO is full.
module ft245_bridge
    import ft245_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int TX_DEPTH      = 16,
    parameter int RX_DEPTH      = 16,
    parameter int STROBE_CYCLES = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int GAP_CYCLES    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [DATA_W-1:0]            rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    input  logic [DATA_W-1:0]            pad_data_i,
    output logic [DATA_W-1:0]            pad_data_o,
    output logic                         pad_data_oe,
    input  logic                         pad_txe_n,
    input  logic                         pad_rxf_n,
    output logic                         pad_wr_n,
    output logic                         pad_rd_n,
    output logic [level_w(TX_DEPTH)-1:0] tx_level,
    output logic [level_w(RX_DEPTH)-1:0] rx_level
);

    localparam int MAX_A   = (STROBE_CYCLES > SETUP_CYCLES) ? STROBE_CYCLES : SETUP_CYCLES;
    localparam int MAX_CNT = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

    // The gap must outlast the flag synchroniser or a stale flag would start a second transfer.
    if (GAP_CYCLES < SYNC_STAGES + 1) begin : g_gap_chk
        $error("ft245_bridge: GAP_CYCLES must be at least SYNC_STAGES+1");
    end
    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("ft245_bridge: SYNC_STAGES must be at least 2");
    end

    // ---------------- flag synchronisers ----------------
    logic [SYNC_STAGES-1:0] txe_sync_q, txe_sync_d;
    logic [SYNC_STAGES-1:0] rxf_sync_q, rxf_sync_d;
    logic                   txe_s;
    logic                   rxf_s;

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        if (g == 0) begin : g_first
            assign txe_sync_d[g] = pad_txe_n;
            assign rxf_sync_d[g] = pad_rxf_n;
        end else begin : g_next
            assign txe_sync_d[g] = txe_sync_q[g-1];
            assign rxf_sync_d[g] = rxf_sync_q[g-1];
        end
    end

    // Synchroniser chains reset to the inactive (high) flag level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txe_sync_q <= '1;
            rxf_sync_q <= '1;
        end else begin
            txe_sync_q <= txe_sync_d;
            rxf_sync_q <= rxf_sync_d;
        end
    end

    assign txe_s = txe_sync_q[SYNC_STAGES-1];
    assign rxf_s = rxf_sync_q[SYNC_STAGES-1];

    // ---------------- FIFOs ----------------
    logic              tx_full, tx_empty, tx_pop;
    logic              rx_full, rx_empty, rx_push;
    logic [DATA_W-1:0] tx_head;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tx_valid),
        .push_dat (tx_data),
        .pop      (tx_pop),
        .pop_dat  (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_level)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rx_push),
        .push_dat (pad_data_i),
        .pop      (rx_ready),
        .pop_dat  (rx_data),
        .full     (rx_full),
        .empty    (rx_empty),
        .level    (rx_level)
    );

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;

    // ---------------- transfer FSM ----------------
    state_e            state_q, state_d;
    dir_e              prio_q, prio_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_ok, wr_ok;

    assign rd_ok = !rxf_s && !rx_full;
    assign wr_ok = !txe_s && !tx_empty;

    // Next state, phase counter, round-robin priority and FIFO strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        rx_push = 1'b0;
        tx_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rd_ok && (!wr_ok || prio_q == DIR_RX)) begin
                    state_d = ST_RD_STROBE;
                end else if (wr_ok) begin
                    state_d = ST_WR_SETUP;
                end
            end
            ST_RD_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    rx_push = 1'b1;
                    cnt_d   = '0;
                    prio_d  = (prio_q == DIR_RX) ? DIR_TX : DIR_RX;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WR_STROBE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                tx_pop  = 1'b1;
                cnt_d   = '0;
                prio_d  = (prio_q == DIR_RX) ? DIR_TX : DIR_RX;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, phase counter and priority registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prio_q  <= DIR_RX;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
        end
    end

    // ---------------- pad outputs ----------------
    logic              wr_n_q, wr_n_d;
    logic              rd_n_q, rd_n_d;
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_phase;

    // Pad pins decoded from the next state so they come straight from flops, glitch-free.
    always_comb begin
        wr_phase = state_d inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD};
        oe_d     = wr_phase;
        data_d   = wr_phase ? tx_head : '0;
        wr_n_d   = (state_d != ST_WR_STROBE);
        rd_n_d   = (state_d != ST_RD_STROBE);
    end

    // Pad output registers; reset releases the bus and parks both strobes high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_n_q <= 1'b1;
            rd_n_q <= 1'b1;
            oe_q   <= 1'b0;
            data_q <= '0;
        end else begin
            wr_n_q <= wr_n_d;
            rd_n_q <= rd_n_d;
            oe_q   <= oe_d;
            data_q <= data_d;
        end
    end

    assign pad_wr_n    = wr_n_q;
    assign pad_rd_n    = rd_n_q;
    assign pad_data_oe = oe_q;
    assign pad_data_o  = data_q;

endmodule

// File: tb/tb_ft245_bridge.sv
// Self-checking bench for ft245_bridge with a pad-side host model and scoreboards.
// Latency: expectations are queued on stimulus and compared when bytes appear.
// Backpressure: exercises RX FIFO full (reads stall) and TX FIFO full (tx_ready low).
module tb_ft245_bridge;

    localparam int STROBE = 4;
    localparam int SETUP  = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] pad_data_i = 8'h00;
    logic [7:0] pad_data_o;
    logic       pad_data_oe;
    logic       pad_txe_n;
    logic       pad_rxf_n = 1'b1;
    logic       pad_wr_n;
    logic       pad_rd_n;
    logic [4:0] tx_level;
    logic [4:0] rx_level;

    always #5 clk = ~clk;

    ft245_bridge #(
        .DATA_W(8), .SYNC_STAGES(2), .TX_DEPTH(16), .RX_DEPTH(16),
        .STROBE_CYCLES(STROBE), .SETUP_CYCLES(SETUP), .GAP_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .pad_data_i(pad_data_i), .pad_data_o(pad_data_o), .pad_data_oe(pad_data_oe),
        .pad_txe_n(pad_txe_n), .pad_rxf_n(pad_rxf_n),
        .pad_wr_n(pad_wr_n), .pad_rd_n(pad_rd_n),
        .tx_level(tx_level), .rx_level(rx_level)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] host_q[$];
    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] wr_bytes_q[$];
    bit         seq_q[$];
    bit         host_en = 1'b0;
    logic [7:0] host_dummy;

    int         rd_len = 0, rd_count = 0, rd_last_len = 0;
    int         wr_setup = 0, wr_len = 0, wr_hold = 0, wr_count = 0;
    int         wr_last_setup = 0, wr_last_len = 0, wr_last_hold = 0;
    logic [7:0] wr_byte = 8'h00;
    bit         wr_unstable = 1'b0, wr_last_unstable = 1'b0, viol = 1'b0;

    // Host model and strobe monitor, acting just after each falling edge.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            rd_len = 0; wr_setup = 0; wr_len = 0; wr_hold = 0; wr_unstable = 1'b0;
        end else begin
            if (!pad_rd_n) begin
                if (rd_len == 0) seq_q.push_back(1'b0);
                rd_len++;
            end else if (rd_len > 0) begin
                rd_last_len = rd_len;
                rd_count++;
                rd_len = 0;
                if (host_q.size() > 0) host_dummy = host_q.pop_front();
            end
            if (pad_data_oe) begin
                if (!pad_wr_n) begin
                    if (wr_len == 0) begin
                        wr_byte = pad_data_o;
                        seq_q.push_back(1'b1);
                    end
                    wr_len++;
                end else if (wr_len == 0) begin
                    wr_setup++;
                end else begin
                    wr_hold++;
                end
                if (wr_len > 0 && pad_data_o !== wr_byte) wr_unstable = 1'b1;
            end else if (wr_setup > 0 || wr_len > 0) begin
                wr_last_setup    = wr_setup;
                wr_last_len      = wr_len;
                wr_last_hold     = wr_hold;
                wr_last_unstable = wr_unstable;
                wr_bytes_q.push_back(wr_byte);
                wr_count++;
                wr_setup = 0; wr_len = 0; wr_hold = 0; wr_unstable = 1'b0;
            end
            if ((pad_data_oe && !pad_rd_n) || (!pad_wr_n && !pad_data_oe)) viol = 1'b1;
        end
        pad_rxf_n  = !(host_en && host_q.size() > 0);
        pad_data_i = (host_q.size() > 0) ? host_q[0] : 8'h00;
    end

    task automatic test_reset();
        reset = 1'b1; pad_txe_n = 1'b1; host_en = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pad_wr_n !== 1'b1 || pad_rd_n !== 1'b1 || pad_data_oe !== 1'b0 || pad_data_o !== 8'h00 ||
            tx_ready !== 1'b1 || rx_valid !== 1'b0 || tx_level !== 5'd0 || rx_level !== 5'd0)
        begin
            errors++;
            $display("FAIL reset_values: wr_n=%b rd_n=%b oe=%b do=%h tx_rdy=%b rx_vld=%b txl=%0d rxl=%0d, want 1 1 0 00 1 0 0 0",
                     pad_wr_n, pad_rd_n, pad_data_oe, pad_data_o, tx_ready, rx_valid, tx_level, rx_level);
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (pad_wr_n !== 1'b1 || pad_rd_n !== 1'b1 || pad_data_oe !== 1'b0 ||
                tx_level !== 5'd0 || rx_level !== 5'd0) begin
                errors++;
                $display("FAIL idle_pins cycle %0d: wr_n=%b rd_n=%b oe=%b txl=%0d rxl=%0d, want 1 1 0 0 0",
                         i, pad_wr_n, pad_rd_n, pad_data_oe, tx_level, rx_level);
            end
        end
    endtask

    task automatic test_rx_single();
        int r0;
        logic [7:0] exp;
        r0 = rd_count;
        host_q.push_back(8'hA5); rx_exp_q.push_back(8'hA5);
        host_en = 1'b1;
        for (int i = 0; i < 60 && !rx_valid; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || rd_count - r0 != 1) begin
            errors++;
            $display("FAIL rx_single_read: rx_valid=%b reads=%0d, want 1 and 1", rx_valid, rd_count - r0);
        end
        checks++;
        if (rd_last_len != STROBE) begin
            errors++;
            $display("FAIL rx_strobe_len: got %0d clocks, want %0d", rd_last_len, STROBE);
        end
        exp = rx_exp_q.pop_front();
        checks++;
        if (rx_data !== exp || rx_level !== 5'd1) begin
            errors++;
            $display("FAIL rx_single_data: data=%h level=%0d, want %h and 1", rx_data, rx_level, exp);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++;
        if (rx_level !== 5'd0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_single_pop: level=%0d valid=%b, want 0 0", rx_level, rx_valid);
        end
        host_en = 1'b0;
    endtask

    task automatic test_tx_single();
        int w0;
        logic [7:0] exp, got;
        pad_txe_n = 1'b1;
        tx_data = 8'h3C; tx_valid = 1'b1;
        if (tx_ready) tx_exp_q.push_back(8'h3C);
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (tx_level !== 5'd1) begin
            errors++;
            $display("FAIL tx_level_push: got %0d, want 1", tx_level);
        end
        w0 = wr_count;
        pad_txe_n = 1'b0;
        for (int i = 0; i < 100 && wr_count == w0; i++) @(negedge clk);
        checks++;
        if (wr_count - w0 != 1) begin
            errors++;
            $display("FAIL tx_single_write: got %0d writes, want 1", wr_count - w0);
        end
        checks++;
        if (wr_last_setup != SETUP || wr_last_len != STROBE || wr_last_hold != 1 || wr_last_unstable) begin
            errors++;
            $display("FAIL tx_timing: setup=%0d strobe=%0d hold=%0d unstable=%b, want %0d %0d 1 0",
                     wr_last_setup, wr_last_len, wr_last_hold, wr_last_unstable, SETUP, STROBE);
        end
        exp = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
        got = (wr_bytes_q.size() > 0) ? wr_bytes_q.pop_front() : 8'hxx;
        checks++;
        if (got !== exp || tx_level !== 5'd0) begin
            errors++;
            $display("FAIL tx_single_data: byte=%h level=%0d, want %h and 0", got, tx_level, exp);
        end
        pad_txe_n = 1'b1;
    endtask

    task automatic test_alternate();
        int s0, r0, w0;
        logic [7:0] exp, got;
        pad_txe_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tx_data = 8'(i); tx_valid = 1'b1;
            if (tx_ready) tx_exp_q.push_back(8'(i));
            @(negedge clk);
        end
        tx_valid = 1'b0;
        s0 = seq_q.size(); r0 = rd_count; w0 = wr_count; viol = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            host_q.push_back(8'(8'h10 + i)); rx_exp_q.push_back(8'(8'h10 + i));
        end
        host_en = 1'b1; pad_txe_n = 1'b0;
        for (int i = 0; i < 400 && (rd_count - r0 < 4 || wr_count - w0 < 4); i++) @(negedge clk);
        checks++;
        if (rd_count - r0 != 4 || wr_count - w0 != 4) begin
            errors++;
            $display("FAIL alt_counts: reads=%0d writes=%0d, want 4 4", rd_count - r0, wr_count - w0);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seq_q.size() <= s0 + k || seq_q[s0 + k] != bit'(k % 2)) begin
                errors++;
                $display("FAIL alt_order slot %0d: got %s, want %s", k,
                         (seq_q.size() <= s0 + k) ? "none" : (seq_q[s0 + k] ? "WR" : "RD"),
                         (k % 2) ? "WR" : "RD");
            end
        end
        for (int k = 0; k < 4; k++) begin
            exp = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
            got = (wr_bytes_q.size() > 0) ? wr_bytes_q.pop_front() : 8'hxx;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL alt_tx_byte %0d: got %h, want %h", k, got, exp);
            end
        end
        host_en = 1'b0; pad_txe_n = 1'b1;
        repeat (5) @(negedge clk);
        rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== exp) begin
                errors++;
                $display("FAIL alt_rx_byte %0d: valid=%b data=%h, want 1 %h", k, rx_valid, rx_data, exp);
            end
            @(negedge clk);
        end
        rx_ready = 1'b0;
        checks++;
        if (viol) begin
            errors++;
            $display("FAIL bus_exclusion: oe overlapped rd_n or wr_n low without oe, want none");
        end
    endtask

    task automatic test_rx_full();
        int r0;
        logic [7:0] exp;
        r0 = rd_count; rx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            host_q.push_back(8'(8'h80 + i)); rx_exp_q.push_back(8'(8'h80 + i));
        end
        host_en = 1'b1;
        for (int i = 0; i < 600 && rx_level != 5'd16; i++) @(negedge clk);
        repeat (100) @(negedge clk);
        checks++;
        if (rd_count - r0 != 16 || rx_level !== 5'd16 || pad_rd_n !== 1'b1) begin
            errors++;
            $display("FAIL rx_full_stall: reads=%0d level=%0d rd_n=%b, want 16 16 1",
                     rd_count - r0, rx_level, pad_rd_n);
        end
        exp = rx_exp_q.pop_front();
        checks++;
        if (rx_data !== exp) begin
            errors++;
            $display("FAIL rx_full_head: got %h, want %h", rx_data, exp);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++;
        if (rx_level !== 5'd15) begin
            errors++;
            $display("FAIL rx_full_pop: level=%0d, want 15", rx_level);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (rd_count - r0 != 17 || rx_level !== 5'd16) begin
            errors++;
            $display("FAIL rx_full_refill: reads=%0d level=%0d, want 17 16", rd_count - r0, rx_level);
        end
        host_en = 1'b0;
        repeat (5) @(negedge clk);
        rx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== exp) begin
                errors++;
                $display("FAIL rx_full_drain %0d: valid=%b data=%h, want 1 %h", k, rx_valid, rx_data, exp);
            end
            @(negedge clk);
        end
        rx_ready = 1'b0;
        host_q.delete(); rx_exp_q.delete();
    endtask

    task automatic test_tx_fill();
        int acc, w0;
        logic [7:0] exp, got;
        pad_txe_n = 1'b1; acc = 0;
        for (int i = 0; i < 17; i++) begin
            tx_data = 8'(8'h40 + i); tx_valid = 1'b1;
            if (tx_ready) begin
                acc++;
                tx_exp_q.push_back(8'(8'h40 + i));
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        checks++;
        if (acc != 16 || tx_ready !== 1'b0 || tx_level !== 5'd16) begin
            errors++;
            $display("FAIL tx_fill: accepted=%0d ready=%b level=%0d, want 16 0 16", acc, tx_ready, tx_level);
        end
        w0 = wr_count; pad_txe_n = 1'b0;
        for (int i = 0; i < 1000 && wr_count - w0 < 16; i++) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            exp = (tx_exp_q.size() > 0) ? tx_exp_q.pop_front() : 8'hxx;
            got = (wr_bytes_q.size() > 0) ? wr_bytes_q.pop_front() : 8'hxx;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL tx_fill_byte %0d: got %h, want %h", k, got, exp);
            end
        end
        checks++;
        if (tx_level !== 5'd0 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_drain: level=%0d ready=%b, want 0 1", tx_level, tx_ready);
        end
        pad_txe_n = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        tx_data = 8'h5A; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0; pad_txe_n = 1'b0;
        for (int i = 0; i < 60 && pad_wr_n !== 1'b0; i++) @(negedge clk);
        checks++;
        if (pad_wr_n !== 1'b0 || pad_data_oe !== 1'b1) begin
            errors++;
            $display("FAIL mid_write_reach: wr_n=%b oe=%b, want 0 1", pad_wr_n, pad_data_oe);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (pad_wr_n !== 1'b1 || pad_data_oe !== 1'b0 || pad_rd_n !== 1'b1 || tx_level !== 5'd0) begin
            errors++;
            $display("FAIL mid_write_reset: wr_n=%b oe=%b rd_n=%b txl=%0d, want 1 0 1 0",
                     pad_wr_n, pad_data_oe, pad_rd_n, tx_level);
        end
        @(negedge clk);
        reset = 1'b0; pad_txe_n = 1'b1;
        tx_exp_q.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (pad_wr_n !== 1'b1 || pad_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: wr_n=%b oe=%b, want 1 0", pad_wr_n, pad_data_oe);
        end
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_tx_single();
        test_alternate();
        test_rx_full();
        test_tx_fill();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
